orao_tape_rec: RTL and testbench

- Cassette recorder: the write-direction counterpart of the tape playback path in the Orao I/O block.
- Watches CPU accesses to the tape/speaker flip-flop window (addr[15:11] = 5'b10001, qualified by ce) and times the intervals between flip-flop toggles.
- Each full square-wave period is decoded into one bit, LSB first; every 8 bits form a byte.
- Bytes are stored in an internal buffer that the framework reads back over the ioctl upload interface as a .tap file.

---
 rtl/orao_tape_rec.sv | 167 ++++++++++++++++
 tb/tb_orao_tape_rec.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/orao_tape_rec.sv
// Orao cassette recorder: decodes CPU-toggled tape square waves into bytes and
// serves them back over ioctl upload. Optional monitor output: ORAO_TAPE_REC_MONITOR_EN.
module orao_tape_rec #(
  parameter int unsigned BUF_AW  = 16,
  parameter logic [15:0] SPLIT   = 16'd48,
  parameter logic [15:0] MIN_PER = 16'd8,
  parameter logic [15:0] TIMEOUT = 16'd4096
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ce_i,
  input  logic [15:0]     addr_i,
  input  logic            rec_arm_i,
  input  logic            ioctl_upload_i,
  input  logic [26:0]     ioctl_addr_i,
  output logic [7:0]      ioctl_din_o,
  output logic [BUF_AW:0] rec_len_o,
  output logic            rec_busy_o,
  output logic            rec_ovf_o,
  output logic            tape_lvl_o,
  output logic            mon_audio_o
);

  localparam int unsigned Depth = 2 ** BUF_AW;
  localparam logic [BUF_AW:0] LenFull = {1'b1, {BUF_AW{1'b0}}};
  localparam logic [BUF_AW:0] LenOne  = {{BUF_AW{1'b0}}, 1'b1};

  typedef enum logic {StIdle, StMeasure} state_e;

  state_e            state_q, state_d;
  logic [15:0]       per_cnt_q, per_cnt_d;
  logic              half_q, half_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              lvl_q, lvl_d;
  logic [BUF_AW:0]   rec_len_q, rec_len_d;
  logic              len_inc_q, len_inc_d;
  logic              ovf_q, ovf_d;
  logic              arm_q;
  logic              in_range_q, in_range_d;
  logic [7:0]        rd_q;
  logic              we;
  logic              bit_v;
  logic              toggle;
  logic              arm_rise;
  logic              buf_full;
  logic              unused_addr;

  logic [7:0] mem_q [Depth];

  assign unused_addr = ^addr_i[10:0];

  // Toggles are invisible while the framework is uploading.
  assign toggle   = ce_i && (addr_i[15:11] == 5'b10001) && !ioctl_upload_i;
  assign arm_rise = rec_arm_i && !arm_q;
  assign buf_full = (rec_len_q == LenFull);
  assign in_range_d = ioctl_addr_i < {{(26 - BUF_AW){1'b0}}, rec_len_q};

  always_comb begin
    state_d   = state_q;
    per_cnt_d = (ce_i && per_cnt_q != 16'hFFFF) ? per_cnt_q + 16'd1 : per_cnt_q;
    half_d    = half_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    lvl_d     = toggle ? ~lvl_q : lvl_q;
    len_inc_d = 1'b0;
    ovf_d     = ovf_q;
    rec_len_d = len_inc_q ? rec_len_q + LenOne : rec_len_q;
    we        = 1'b0;
    bit_v     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rec_arm_i && toggle) begin
          state_d   = StMeasure;
          per_cnt_d = 16'd0;
          bit_idx_d = 3'd0;
          half_d    = 1'b0;
        end
      end
      StMeasure: begin
        if (!rec_arm_i || ioctl_upload_i) begin
          state_d = StIdle;
        end else if (per_cnt_q >= TIMEOUT) begin
          state_d = StIdle;
        end else if (toggle) begin
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d    = 1'b0;
            per_cnt_d = 16'd0;
            // Periods shorter than MIN_PER are glitches and leave the byte untouched.
            if (per_cnt_q >= MIN_PER) begin
              bit_v     = (per_cnt_q >= SPLIT);
              shift_d   = {bit_v, shift_q[7:1]};
              bit_idx_d = bit_idx_q + 3'd1;
              if (bit_idx_q == 3'd7) begin
                if (buf_full) begin
                  ovf_d = 1'b1;
                end else begin
                  we        = 1'b1;
                  len_inc_d = 1'b1;
                end
              end
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A fresh arm starts a new tape.
    if (arm_rise) begin
      rec_len_d = '0;
      ovf_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      per_cnt_q  <= 16'd0;
      half_q     <= 1'b0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      lvl_q      <= 1'b0;
      rec_len_q  <= '0;
      len_inc_q  <= 1'b0;
      ovf_q      <= 1'b0;
      arm_q      <= 1'b0;
      in_range_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      per_cnt_q  <= per_cnt_d;
      half_q     <= half_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      lvl_q      <= lvl_d;
      rec_len_q  <= rec_len_d;
      len_inc_q  <= len_inc_d;
      ovf_q      <= ovf_d;
      arm_q      <= rec_arm_i;
      in_range_q <= in_range_d;
    end
  end

  // Simple dual-port RAM: record writes, upload reads with one clock of latency.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem_q[rec_len_q[BUF_AW-1:0]] <= shift_d;
    end
    rd_q <= mem_q[ioctl_addr_i[BUF_AW-1:0]];
  end

  assign ioctl_din_o = in_range_q ? rd_q : 8'h00;
  assign rec_len_o   = rec_len_q;
  assign rec_busy_o  = (state_q == StMeasure);
  assign rec_ovf_o   = ovf_q;
  assign tape_lvl_o  = lvl_q;

`ifdef ORAO_TAPE_REC_MONITOR_EN
  assign mon_audio_o = lvl_q & (state_q == StMeasure);
`else
  assign mon_audio_o = 1'b0;
`endif

endmodule

// File: tb/tb_orao_tape_rec.sv
// Randomized bench for orao_tape_rec: drives tape waveforms in ce ticks and
// compares against a byte-level model of the recorded tape.
module tb_orao_tape_rec;

  localparam int unsigned AW = 4;
  localparam int Cap = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        ce_i = 1'b0;
  logic [15:0] addr_i = 16'h0;
  logic        rec_arm_i = 1'b0;
  logic        ioctl_upload_i = 1'b0;
  logic [26:0] ioctl_addr_i = 27'h0;
  logic [7:0]  ioctl_din_o;
  logic [AW:0] rec_len_o;
  logic        rec_busy_o;
  logic        rec_ovf_o;
  logic        tape_lvl_o;
  logic        mon_audio_o;

  orao_tape_rec #(.BUF_AW(AW)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .ce_i           (ce_i),
    .addr_i         (addr_i),
    .rec_arm_i      (rec_arm_i),
    .ioctl_upload_i (ioctl_upload_i),
    .ioctl_addr_i   (ioctl_addr_i),
    .ioctl_din_o    (ioctl_din_o),
    .rec_len_o      (rec_len_o),
    .rec_busy_o     (rec_busy_o),
    .rec_ovf_o      (rec_ovf_o),
    .tape_lvl_o     (tape_lvl_o),
    .mon_audio_o    (mon_audio_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the tape as a list of bytes.
  logic [7:0] exp_buf [Cap];
  int         exp_len = 0;
  logic       exp_ovf = 1'b0;
  logic       exp_lvl = 1'b0;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // One ce tick, preceded by a random number of ce-idle clocks.
  task automatic tick(input bit tog);
    int gap;
    gap = $urandom_range(0, 1);
    for (int i = 0; i < gap; i++) begin
      ce_i = 1'b0;
      addr_i = 16'($urandom);
      step();
    end
    ce_i = 1'b1;
    if (tog) begin
      addr_i = {5'b10001, 11'($urandom)};
    end else begin
      addr_i = 16'($urandom);
      if (addr_i[15:11] == 5'b10001) addr_i[15] = 1'b0;
    end
    step();
    ce_i = 1'b0;
    if (tog && !ioctl_upload_i) exp_lvl = ~exp_lvl;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  // Full period of t ticks between toggles, mid toggle after h ticks.
  task automatic send_period(input int t, input int h);
    idle_ticks(h - 1);
    tick(1'b1);
    idle_ticks(t - h - 1);
    tick(1'b1);
  endtask

  task automatic send_bit(input bit b);
    int t;
    t = b ? $urandom_range(50, 80) : $urandom_range(10, 46);
    send_period(t, $urandom_range(1, t - 1));
  endtask

  task automatic send_glitch();
    int t;
    t = $urandom_range(2, 6);
    send_period(t, $urandom_range(1, t - 1));
  endtask

  task automatic model_store(input logic [7:0] b);
    if (exp_len == Cap) begin
      exp_ovf = 1'b1;
    end else begin
      exp_buf[exp_len] = b;
      exp_len++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    model_store(b);
  endtask

  task automatic start_rec();
    tick(1'b1);
  endtask

  // A one-clock upload pulse drops the recorder to idle without clearing the tape.
  task automatic end_session();
    ce_i = 1'b0;
    ioctl_upload_i = 1'b1;
    step();
    ioctl_upload_i = 1'b0;
    step();
  endtask

  task automatic rearm();
    rec_arm_i = 1'b0;
    step();
    rec_arm_i = 1'b1;
    step();
    exp_len = 0;
    exp_ovf = 1'b0;
  endtask

  task automatic upload_read(input int a, output logic [7:0] d);
    ioctl_upload_i = 1'b1;
    ioctl_addr_i = 27'(a);
    step();
    d = ioctl_din_o;
  endtask

  function automatic logic [7:0] model_read(input int a);
    return (a < exp_len) ? exp_buf[a % Cap] : 8'h00;
  endfunction

  task automatic test_reset();
    rst_ni = 1'b0;
    #2;
    n_vec++;
    if ({ioctl_din_o, rec_len_o, rec_busy_o, rec_ovf_o, tape_lvl_o, mon_audio_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %0h required 0",
               {ioctl_din_o, rec_len_o, rec_busy_o, rec_ovf_o, tape_lvl_o, mon_audio_o});
    end
    step();
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_single_byte();
    logic [7:0] d;
    logic       exp_mon;
    rearm();
    start_rec();
    n_vec++;
    if (rec_busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL busy_on_start: got %b required 1", rec_busy_o);
    end
    for (int i = 0; i < 8; i++) send_period(64, 32);
    model_store(8'hFF);
    idle_ticks(2);
    n_vec++;
    if (rec_len_o !== (AW + 1)'(exp_len)) begin
      n_err++;
      $display("FAIL len_after_ff: got %0d required %0d", rec_len_o, exp_len);
    end
    n_vec++;
    if (tape_lvl_o !== exp_lvl) begin
      n_err++;
      $display("FAIL tape_lvl: got %b required %b", tape_lvl_o, exp_lvl);
    end
`ifdef ORAO_TAPE_REC_MONITOR_EN
    exp_mon = exp_lvl;
`else
    exp_mon = 1'b0;
`endif
    n_vec++;
    if (mon_audio_o !== exp_mon) begin
      n_err++;
      $display("FAIL mon_audio: got %b required %b", mon_audio_o, exp_mon);
    end
    idle_ticks(3990);
    n_vec++;
    if (rec_busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL busy_before_timeout: got %b required 1", rec_busy_o);
    end
    idle_ticks(200);
    n_vec++;
    if (rec_busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL busy_after_timeout: got %b required 0", rec_busy_o);
    end
    upload_read(0, d);
    ioctl_upload_i = 1'b0;
    n_vec++;
    if (d !== 8'hFF) begin
      n_err++;
      $display("FAIL read_ff: got %02h required ff", d);
    end
  endtask

  task automatic test_alternating();
    logic [7:0] d;
    start_rec();
    for (int i = 0; i < 8; i++) send_period((i % 2 == 0) ? 32 : 64, (i % 2 == 0) ? 16 : 32);
    model_store(8'hAA);
    end_session();
    upload_read(exp_len - 1, d);
    ioctl_upload_i = 1'b0;
    n_vec++;
    if (d !== 8'hAA || rec_len_o !== (AW + 1)'(exp_len)) begin
      n_err++;
      $display("FAIL alternating_aa: got %02h/len %0d required aa/len %0d", d, rec_len_o, exp_len);
    end
  endtask

  task automatic test_timeout_partial();
    logic [7:0] d;
    logic [7:0] x;
    start_rec();
    for (int i = 0; i < 5; i++) send_bit(1'($urandom));
    idle_ticks(4200);
    n_vec++;
    if (rec_busy_o !== 1'b0 || rec_len_o !== (AW + 1)'(exp_len)) begin
      n_err++;
      $display("FAIL partial_discard: got busy %b len %0d required busy 0 len %0d",
               rec_busy_o, rec_len_o, exp_len);
    end
    x = 8'($urandom);
    start_rec();
    send_byte(x);
    end_session();
    upload_read(exp_len - 1, d);
    ioctl_upload_i = 1'b0;
    n_vec++;
    if (d !== x) begin
      n_err++;
      $display("FAIL fresh_byte: got %02h required %02h", d, x);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] d;
    logic [7:0] b;
    b = 8'h5A;
    start_rec();
    for (int i = 0; i < 8; i++) begin
      send_bit(b[i]);
      if (i == 3 || (i < 7 && $urandom_range(0, 1) == 1)) send_glitch();
    end
    model_store(b);
    end_session();
    upload_read(exp_len - 1, d);
    ioctl_upload_i = 1'b0;
    n_vec++;
    if (d !== 8'h5A || rec_len_o !== (AW + 1)'(exp_len)) begin
      n_err++;
      $display("FAIL glitch_5a: got %02h/len %0d required 5a/len %0d", d, rec_len_o, exp_len);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    int         a;
    rearm();
    n_vec++;
    if (rec_len_o !== '0 || rec_ovf_o !== 1'b0) begin
      n_err++;
      $display("FAIL rearm_clear: got len %0d ovf %b required 0 0", rec_len_o, rec_ovf_o);
    end
    start_rec();
    for (int i = 0; i < 16; i++) send_byte(8'($urandom));
    end_session();
    n_vec++;
    if (rec_len_o !== 5'd16 || rec_ovf_o !== 1'b0) begin
      n_err++;
      $display("FAIL full_no_ovf: got len %0d ovf %b required 16 0", rec_len_o, rec_ovf_o);
    end
    start_rec();
    send_byte(8'($urandom));
    end_session();
    n_vec++;
    if (rec_len_o !== (AW + 1)'(exp_len) || rec_ovf_o !== exp_ovf) begin
      n_err++;
      $display("FAIL overflow: got len %0d ovf %b required %0d %b",
               rec_len_o, rec_ovf_o, exp_len, exp_ovf);
    end
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 0 : (i == 1) ? 15 : (i == 2) ? 16 : $urandom_range(0, 15);
      upload_read(a, d);
      n_vec++;
      if (d !== model_read(a)) begin
        n_err++;
        $display("FAIL ovf_read[%0d]: got %02h required %02h", a, d, model_read(a));
      end
    end
    ioctl_upload_i = 1'b0;
    rearm();
    n_vec++;
    if (rec_len_o !== '0 || rec_ovf_o !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_rearm: got len %0d ovf %b required 0 0", rec_len_o, rec_ovf_o);
    end
  endtask

  task automatic test_upload();
    logic [7:0] d;
    logic       lvl_before;
    start_rec();
    send_byte(8'h12);
    send_byte(8'h34);
    end_session();
    for (int a = 0; a < 3; a++) begin
      upload_read(a, d);
      n_vec++;
      if (d !== model_read(a)) begin
        n_err++;
        $display("FAIL upload_read[%0d]: got %02h required %02h", a, d, model_read(a));
      end
    end
    lvl_before = exp_lvl;
    for (int i = 0; i < 3; i++) tick(1'b1);
    n_vec++;
    if (tape_lvl_o !== lvl_before || rec_busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL upload_hold: got lvl %b busy %b required %b 0", tape_lvl_o, rec_busy_o,
               lvl_before);
    end
    ioctl_upload_i = 1'b0;
    step();
  endtask

  task automatic test_random_bytes();
    logic [7:0] d;
    int         n;
    int         a;
    rearm();
    n = $urandom_range(3, 6);
    start_rec();
    for (int i = 0; i < n; i++) send_byte(8'($urandom));
    end_session();
    for (int i = 0; i < n + 4; i++) begin
      a = (i < n) ? i : (i == n) ? n : (i == n + 1) ? (32'h10 | 32'($urandom_range(0, 3)))
          : 32'($urandom_range(0, 15));
      upload_read(a, d);
      n_vec++;
      if (d !== model_read(a)) begin
        n_err++;
        $display("FAIL random_read[%0h]: got %02h required %02h", a, d, model_read(a));
      end
    end
    ioctl_upload_i = 1'b0;
    step();
    n_vec++;
    if (rec_len_o !== (AW + 1)'(exp_len) || tape_lvl_o !== exp_lvl) begin
      n_err++;
      $display("FAIL random_len_lvl: got %0d/%b required %0d/%b", rec_len_o, tape_lvl_o,
               exp_len, exp_lvl);
    end
  endtask

  task automatic test_reset_mid();
    start_rec();
    for (int i = 0; i < 3; i++) send_bit(1'($urandom));
    #2;
    rst_ni = 1'b0;
    #1;
    exp_len = 0;
    exp_ovf = 1'b0;
    exp_lvl = 1'b0;
    n_vec++;
    if ({rec_len_o, rec_busy_o, rec_ovf_o, tape_lvl_o, ioctl_din_o} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got %0h required 0",
               {rec_len_o, rec_busy_o, rec_ovf_o, tape_lvl_o, ioctl_din_o});
    end
    step();
    rst_ni = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_alternating();
    test_timeout_partial();
    test_glitch();
    test_overflow();
    test_upload();
    test_random_bytes();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
